mic1_uart_rx: RTL and testbench

MIC1_UART_RX -- requirements
Module: mic1_uart_rx

---
 rtl/mic1_uart_pkg.sv | 24 ++
 rtl/mic1_uart_rx_fifo.sv | 92 +++++++++
 rtl/mic1_uart_rx.sv | 148 ++++++++++++++
 tb/tb_mic1_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_uart_pkg.sv
// Shared 8N1 UART constants and receiver state encoding, common to the
// receiver and transmitter.
package mic1_uart_pkg;

   localparam int   DEFAULT_CLKS_PER_BIT = 625;   // 6 MHz / 9600 baud
   localparam int   DATA_BITS            = 8;
   localparam logic START_LEVEL          = 1'b0;
   localparam logic STOP_LEVEL           = 1'b1;
   localparam logic IDLE_LEVEL           = 1'b1;
   localparam int   SYNC_STAGES          = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   function automatic int half_bit(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/mic1_uart_rx_fifo.sv
// Receive byte queue. MIC1_UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO;
// otherwise a single holding register. A full queue drops pushes unless popped that cycle.
module mic1_uart_rx_fifo
   import mic1_uart_pkg::*;
`ifdef MIC1_UART_RX_FIFO_EN
#(
   parameter int FIFO_DEPTH = 4
)
`endif
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_push,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_pop,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_overrun
);

   logic r_overrun;
   logic w_pop;
   logic w_write;

`ifdef MIC1_UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic                 w_empty;
   logic                 w_full;

   // Extra MSB on each pointer distinguishes full from empty when indices match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_pop && !w_empty;
   assign w_write = i_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_overrun <= i_push && !w_write;
      end
   end

   assign o_valid = !w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
`else
   logic [DATA_BITS-1:0] r_hold;
   logic                 r_full;

   assign w_pop   = i_pop && r_full;
   assign w_write = i_push && (!r_full || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold    <= '0;
         r_full    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_write) begin
            r_hold <= i_data;
         end
         r_full    <= w_write || (r_full && !w_pop);
         r_overrun <= i_push && !w_write;
      end
   end

   assign o_valid = r_full;
   assign o_data  = r_hold;
`endif

   assign o_overrun = r_overrun;

endmodule

// File: rtl/mic1_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, byte queue.
// Define MIC1_UART_RX_FIFO_EN for a FIFO_DEPTH-deep queue instead of one holding register.
module mic1_uart_rx
   import mic1_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(half_bit(CLKS_PER_BIT) - 1);
   localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mic1_uart_rx: FIFO_DEPTH must be a power of two >= 2");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rx_s;
   rx_state_t              r_state;
   rx_state_t              w_state_next;
   logic [CW-1:0]          r_baud;
   logic [CW-1:0]          w_baud_next;
   logic [BW-1:0]          r_bit;
   logic [BW-1:0]          w_bit_next;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   w_shift_next;
   logic                   r_frame_err;
   logic                   w_frame_err_next;
   logic                   w_push;
   logic                   w_tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      end
   end

   assign w_rx_s = r_sync[SYNC_STAGES-1];
   assign w_tick = (r_baud == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_baud      <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_baud      <= w_baud_next;
         r_bit       <= w_bit_next;
         r_shift     <= w_shift_next;
         r_frame_err <= w_frame_err_next;
      end
   end

   // Every transition reloads the baud counter, so sample points never drift.
   always_comb begin
      w_state_next     = r_state;
      w_baud_next      = w_tick ? r_baud : r_baud - 1'b1;
      w_bit_next       = r_bit;
      w_shift_next     = r_shift;
      w_frame_err_next = 1'b0;
      w_push           = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_rx_s == START_LEVEL) begin
               w_state_next = START;
               w_baud_next  = HALF_RELOAD;
               w_bit_next   = '0;
            end
         end
         START: begin
            if (w_tick) begin
               w_baud_next  = FULL_RELOAD;
               w_state_next = (w_rx_s == START_LEVEL) ? DATA : IDLE;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_baud_next         = FULL_RELOAD;
               w_shift_next[r_bit] = w_rx_s;
               w_bit_next          = r_bit + 1'b1;
               if (r_bit == LAST_BIT) begin
                  w_state_next = STOP;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               w_baud_next = FULL_RELOAD;
               if (w_rx_s == STOP_LEVEL) begin
                  w_push       = 1'b1;
                  w_state_next = IDLE;
               end else begin
                  w_frame_err_next = 1'b1;
                  w_state_next     = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // A held-low break must return high before another start can be seen.
            if (w_rx_s == IDLE_LEVEL) begin
               w_baud_next  = FULL_RELOAD;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   mic1_uart_rx_fifo
`ifdef MIC1_UART_RX_FIFO_EN
      #(.FIFO_DEPTH(FIFO_DEPTH))
`endif
      u_fifo (
         .clk       (clk),
         .reset     (reset),
         .i_push    (w_push),
         .i_data    (r_shift),
         .i_pop     (rx_ready),
         .o_data    (rx_data),
         .o_valid   (rx_valid),
         .o_overrun (overrun)
      );

   assign frame_err = r_frame_err;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mic1_uart_rx.sv
// Randomized self-checking bench for mic1_uart_rx against a queue-based
// model of the receive path; honours MIC1_UART_RX_FIFO_EN for the model depth.
module tb_mic1_uart_rx;

   localparam int CPB  = 32;
   localparam int HALF = CPB / 2;
`ifdef MIC1_UART_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   // Clock edges from the start-bit drive to the stop-bit sample:
   // two synchronizer flops, one IDLE detect edge, half a bit, nine bits.
   localparam int STOP_EDGE = 3 + HALF + 9 * CPB;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       rx       = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   byte unsigned got_q[$];
   byte unsigned model_q[$];
   int           exp_ov;
   int           fe_cnt    = 0;
   int           ov_cnt    = 0;
   int           hold_viol = 0;
   int           fe_base, ov_base, hv_base;
   logic         prev_valid = 1'b0;
   logic         prev_ready = 1'b0;
   logic [7:0]   prev_data  = 8'h00;

   always #5 clk = ~clk;

   mic1_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (frame_err) fe_cnt <= fe_cnt + 1;
         if (overrun)   ov_cnt <= ov_cnt + 1;
         if (prev_valid && !prev_ready && rx_valid && rx_data != prev_data)
            hold_viol <= hold_viol + 1;
      end
      prev_valid <= rx_valid && !reset;
      prev_ready <= rx_ready;
      prev_data  <= rx_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Consumer ready means the queue drains as fast as it fills.
   task automatic model_rx(input byte unsigned b, input bit consumer_ready);
      if (consumer_ready || model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ov++;
   endtask

   task automatic clear_mon();
      got_q.delete();
      model_q.delete();
      exp_ov  = 0;
      fe_base = fe_cnt;
      ov_base = ov_cnt;
      hv_base = hold_viol;
   endtask

   task automatic compare_all(input string tag, input int exp_fe);
      check_eq({tag, ".count"}, got_q.size(), model_q.size());
      for (int i = 0; i < model_q.size() && i < got_q.size(); i++)
         check_eq($sformatf("%s.byte%0d", tag, i), got_q[i], model_q[i]);
      check_eq({tag, ".frame_err"}, fe_cnt - fe_base, exp_fe);
      check_eq({tag, ".overrun"}, ov_cnt - ov_base, exp_ov);
      check_eq({tag, ".hold"}, hold_viol - hv_base, 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
      @(posedge clk); #1 rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clk);
         #1 rx = b[i];
      end
      repeat (CPB) @(posedge clk);
      #1 rx = stop_lvl;
      repeat (CPB) @(posedge clk);
      if (stop_lvl) repeat (4) @(posedge clk);
   endtask

   task automatic wait_not_busy(input string tag, input int limit);
      int k = 0;
      while (busy && k < limit) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq({tag, ".busy_clear"}, busy, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] burst [5];
      burst[0] = 8'h34; burst[1] = 8'h32; burst[2] = 8'h0A; burst[3] = 8'h31; burst[4] = 8'h36;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_eq("rst.valid", rx_valid, 1'b0);
      check_eq("rst.data", rx_data, 8'h00);
      check_eq("rst.frame_err", frame_err, 1'b0);
      check_eq("rst.overrun", overrun, 1'b0);
      check_eq("rst.busy", busy, 1'b0);

      // Single byte with a ready consumer.
      clear_mon();
      rx_ready = 1'b1;
      send_byte(8'h34, 1'b1);
      model_rx(8'h34, 1'b1);
      repeat (4) @(posedge clk);
      compare_all("single", 0);

      // Random bytes, random idle gaps.
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom_range(0, 255));
         send_byte(b, 1'b1);
         model_rx(b, 1'b1);
         repeat ($urandom_range(0, 20)) @(posedge clk);
      end
      repeat (4) @(posedge clk);
      compare_all("rand", 0);

      // Burst into a stalled consumer, then drain.
      clear_mon();
      #1 rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_byte(burst[i], 1'b1);
         model_rx(burst[i], 1'b0);
      end
      repeat (4) @(posedge clk);
      #1;
      check_eq("burst.valid", rx_valid, 1'b1);
      check_eq("burst.head", rx_data, model_q[0]);
      @(posedge clk); #1 rx_ready = 1'b1;
      repeat (DEPTH + 4) @(posedge clk);
      #1;
      compare_all("burst", 0);
      check_eq("burst.drained", rx_valid, 1'b0);

      // Bad stop bit followed by a 20-bit break.
      clear_mon();
      send_byte(8'h55, 1'b0);
      repeat (20 * CPB) @(posedge clk);
      #1;
      check_eq("break.busy", busy, 1'b1);
      check_eq("break.valid", rx_valid, 1'b0);
      check_eq("break.ferr_once", fe_cnt - fe_base, 1);
      rx = 1'b1;
      wait_not_busy("break", 6);
      repeat (4) @(posedge clk);
      b = 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
      model_rx(b, 1'b1);
      repeat (4) @(posedge clk);
      compare_all("break", 1);

      // Short low glitch: start re-sample sees high.
      clear_mon();
      @(posedge clk); #1 rx = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("glitch.busy_seen", busy, 1'b1);
      rx = 1'b1;
      wait_not_busy("glitch", HALF + 3);
      repeat (4) @(posedge clk);
      compare_all("glitch", 0);

      // Reset during bit 3 of 0x42, then 0x31.
      clear_mon();
      b = 8'h42;
      @(posedge clk); #1 rx = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat (CPB) @(posedge clk);
         #1 rx = b[i];
      end
      repeat (HALF) @(posedge clk);
      #1 reset = 1'b1; rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_eq("rstmid.busy", busy, 1'b0);
      check_eq("rstmid.valid", rx_valid, 1'b0);
      repeat (CPB) @(posedge clk);
      send_byte(8'h31, 1'b1);
      model_rx(8'h31, 1'b1);
      repeat (4) @(posedge clk);
      compare_all("rstmid", 0);

      // Full queue; consumer becomes ready exactly at the next stop sample.
      clear_mon();
      #1 rx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom_range(0, 255));
         send_byte(b, 1'b1);
         model_rx(b, 1'b0);
      end
      b = 8'($urandom_range(0, 255));
      fork
         send_byte(b, 1'b1);
         begin
            repeat (STOP_EDGE) @(posedge clk);
            #1 rx_ready = 1'b1;
         end
      join
      model_rx(b, 1'b1);
      repeat (DEPTH + 4) @(posedge clk);
      #1;
      compare_all("fullpp", 0);
      check_eq("fullpp.drained", rx_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
